// File: rtl/openmips_mem_arbiter_if.sv
// Bundle of fetch-port, data-port, memory-command and stall signals around the
// OpenMIPS memory arbiter. The master side is the pipeline plus memory; the slave side is the arbiter.
interface openmips_mem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              d_req;
  logic              d_we;
  logic [3:0]        d_sel;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              mem_ce;
  logic              mem_we;
  logic [3:0]        mem_sel;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_req_if;
  logic              stall_req_mem;

  modport master (
    output if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
    input  mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
    input  stall_req_if, stall_req_mem
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
    output mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
    output stall_req_if, stall_req_mem
  );
endinterface

// File: rtl/openmips_mem_arbiter.sv
// Shares one fixed-latency single-port memory between OpenMIPS fetch and MEM-stage
// accesses; data wins ties, and a saturating counter forces fetch progress.
module openmips_mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                  clk,
  input logic                  rst,
  openmips_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            r_state;
  logic              r_ownerData;
  logic              r_isWrite;
  logic [2:0]        r_latCnt;
  logic [3:0]        r_starveCnt;
  logic              r_memCe;
  logic              r_memWe;
  logic [3:0]        r_memSel;
  logic [DATA_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic [DATA_W-1:0] r_ifRdata;
  logic [DATA_W-1:0] r_dRdata;
  logic              r_ifAck;
  logic              r_dAck;

  logic              w_starved;
  logic              w_grantData;
  logic [DATA_W-1:0] w_capture;

  // Data normally wins; a saturated counter hands the slot to a waiting fetch.
  assign w_starved   = bus.if_req && (r_starveCnt == STARVE_LIM);
  assign w_grantData = bus.d_req && !w_starved;
  assign w_capture   = r_isWrite ? '0 : bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ownerData <= 1'b0;
      r_isWrite   <= 1'b0;
      r_latCnt    <= '0;
      r_starveCnt <= '0;
      r_memCe     <= 1'b0;
      r_memWe     <= 1'b0;
      r_memSel    <= '0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_ifRdata   <= '0;
      r_dRdata    <= '0;
      r_ifAck     <= 1'b0;
      r_dAck      <= 1'b0;
    end else begin
      r_memCe <= 1'b0;
      r_memWe <= 1'b0;
      r_ifAck <= 1'b0;
      r_dAck  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!bus.if_req) begin
            r_starveCnt <= '0;
          end
          if (w_grantData) begin
            r_ownerData <= 1'b1;
            r_isWrite   <= bus.d_we;
            r_memCe     <= 1'b1;
            r_memWe     <= bus.d_we;
            r_memSel    <= bus.d_sel;
            r_memAddr   <= bus.d_addr;
            r_memWdata  <= bus.d_wdata;
            if (bus.if_req && (r_starveCnt != STARVE_LIM)) begin
              r_starveCnt <= r_starveCnt + 4'd1;
            end
            r_state <= ISSUE;
          end else if (bus.if_req) begin
            r_ownerData <= 1'b0;
            r_isWrite   <= 1'b0;
            r_memCe     <= 1'b1;
            r_memWe     <= 1'b0;
            r_memSel    <= 4'b1111;
            r_memAddr   <= bus.if_addr;
            r_memWdata  <= '0;
            r_starveCnt <= '0;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_latCnt <= LAT_INIT;
          r_state  <= WAIT;
        end
        WAIT: begin
          // Read data lands in the owner's register only; writes return zero.
          if (r_latCnt == 3'd0) begin
            if (r_ownerData) begin
              r_dRdata <= w_capture;
              r_dAck   <= 1'b1;
            end else begin
              r_ifRdata <= w_capture;
              r_ifAck   <= 1'b1;
            end
            r_state <= ACK;
          end else begin
            r_latCnt <= r_latCnt - 3'd1;
          end
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_ce        = r_memCe;
  assign bus.mem_we        = r_memWe;
  assign bus.mem_sel       = r_memSel;
  assign bus.mem_addr      = r_memAddr;
  assign bus.mem_wdata     = r_memWdata;
  assign bus.if_rdata      = r_ifRdata;
  assign bus.if_ack        = r_ifAck;
  assign bus.d_rdata       = r_dRdata;
  assign bus.d_ack         = r_dAck;
  // Stalls are combinational on the live request so ctrl sees them in the request cycle.
  assign bus.stall_req_if  = rst & bus.if_req & ~r_ifAck;
  assign bus.stall_req_mem = rst & bus.d_req & ~r_dAck;

endmodule

// File: tb/tb_openmips_mem_arbiter.sv
// Bench for openmips_mem_arbiter: a latency-exact memory model per DUT and a
// scoreboard of expected ack owner/data pushed when each request is driven.
module tb_openmips_mem_arbiter;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cycNum = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycNum++;

  openmips_mem_arbiter_if #(.DATA_W(DW)) m ();
  openmips_mem_arbiter_if #(.DATA_W(DW)) l1 ();
  openmips_mem_arbiter_if #(.DATA_W(DW)) l7 ();

  openmips_mem_arbiter #(.DATA_W(DW), .MEM_LAT(2), .STARVE_MAX(4)) dut   (.clk(clk), .rst(rst), .bus(m));
  openmips_mem_arbiter #(.DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) dutL1 (.clk(clk), .rst(rst), .bus(l1));
  openmips_mem_arbiter #(.DATA_W(DW), .MEM_LAT(7), .STARVE_MAX(4)) dutL7 (.clk(clk), .rst(rst), .bus(l7));

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h3C010001 ^ a;
  endfunction

  // Memory models drive valid data only in the cycle MEM_LAT after mem_ce.
  int latM = 0, latA = 0, latB = 0;
  logic [31:0] addrM = '0, addrA = '0, addrB = '0;
  always @(posedge clk) begin
    if (m.mem_ce === 1'b1) begin latM <= 2; addrM <= m.mem_addr; end
    else if (latM != 0) latM <= latM - 1;
    if (l1.mem_ce === 1'b1) begin latA <= 1; addrA <= l1.mem_addr; end
    else if (latA != 0) latA <= latA - 1;
    if (l7.mem_ce === 1'b1) begin latB <= 7; addrB <= l7.mem_addr; end
    else if (latB != 0) latB <= latB - 1;
  end
  assign m.mem_rdata  = (latM == 1) ? memWord(addrM) : 32'hBAADF00D;
  assign l1.mem_rdata = (latA == 1) ? memWord(addrA) : 32'hBAADF00D;
  assign l7.mem_rdata = (latB == 1) ? memWord(addrB) : 32'hBAADF00D;

  typedef struct {int cyc; logic we; logic [3:0] sel; logic [31:0] addr; logic [31:0] wdata;} ceRec_t;
  typedef struct {int cyc; logic isData; logic [31:0] rdata;} ackRec_t;
  typedef struct {logic isData; logic [31:0] rdata;} exp_t;

  ceRec_t  ceLog[$];
  ackRec_t ackLog[$];
  exp_t    scoreQ[$];
  int      dualAck = 0;

  always @(negedge clk) begin
    if (m.mem_ce === 1'b1) ceLog.push_back('{cycNum, m.mem_we, m.mem_sel, m.mem_addr, m.mem_wdata});
    if (m.if_ack === 1'b1) ackLog.push_back('{cycNum, 1'b0, m.if_rdata});
    if (m.d_ack === 1'b1) ackLog.push_back('{cycNum, 1'b1, m.d_rdata});
    if (m.if_ack === 1'b1 && m.d_ack === 1'b1) dualAck++;
  end

  // Waits for the next ack on the main DUT, then retires that requester.
  task automatic serveAck(input int bound, output logic isData, output logic [31:0] rdata, output int atCyc);
    atCyc = -1; isData = 1'b0; rdata = '0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (m.d_ack === 1'b1) begin isData = 1'b1; rdata = m.d_rdata; atCyc = cycNum; break; end
      if (m.if_ack === 1'b1) begin isData = 1'b0; rdata = m.if_rdata; atCyc = cycNum; break; end
    end
    @(posedge clk); #1;
    if (atCyc >= 0) begin
      if (isData) m.d_req = 1'b0;
      else m.if_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m.if_req = 1'b1; m.d_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m.mem_ce, m.mem_we, m.if_ack, m.d_ack} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {m.mem_ce, m.mem_we, m.if_ack, m.d_ack});
    end
    checks++;
    if ({m.mem_sel, m.mem_addr, m.mem_wdata} !== 68'h0) begin
      errors++; $display("[TB] FAIL reset_cmd: got %0h expected 0", {m.mem_sel, m.mem_addr, m.mem_wdata});
    end
    checks++;
    if ({m.if_rdata, m.d_rdata} !== 64'h0) begin
      errors++; $display("[TB] FAIL reset_rdata: got %0h expected 0", {m.if_rdata, m.d_rdata});
    end
    checks++;
    if ({m.stall_req_if, m.stall_req_mem} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_stall: got %b expected 00", {m.stall_req_if, m.stall_req_mem});
    end
    checks++;
    if (dut.r_state !== 2'd0 || dut.r_starveCnt !== 4'd0 || dut.r_latCnt !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_state: got state %0d starve %0d lat %0d expected 0 0 0",
                         dut.r_state, dut.r_starveCnt, dut.r_latCnt);
    end
    @(posedge clk); #1;
    m.if_req = 1'b0; m.d_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_only();
    int t0, ackAt;
    logic [31:0] rd;
    exp_t e;
    ceLog.delete();
    t0 = cycNum; ackAt = -1; rd = '0;
    m.if_addr = 32'h100; m.if_req = 1'b1;
    scoreQ.push_back('{1'b0, 32'h3C010101});
    for (int k = 0; k < 12 && ackAt < 0; k++) begin
      @(negedge clk);
      checks++;
      if (m.stall_req_if !== (k < 4)) begin
        errors++; $display("[TB] FAIL fetch_stall_c%0d: got %b expected %b", k, m.stall_req_if, (k < 4));
      end
      if (m.if_ack === 1'b1) begin ackAt = k; rd = m.if_rdata; end
    end
    @(posedge clk); #1;
    m.if_req = 1'b0;
    checks++;
    if (ackAt != 4) begin
      errors++; $display("[TB] FAIL fetch_ack_cycle: got %0d expected 4", ackAt);
    end
    checks++;
    if (scoreQ.size() == 0) begin
      errors++; $display("[TB] FAIL fetch_score: got empty queue expected entry");
    end else begin
      e = scoreQ.pop_front();
      if (rd !== e.rdata) begin
        errors++; $display("[TB] FAIL fetch_rdata: got %h expected %h", rd, e.rdata);
      end
    end
    checks++;
    if (ceLog.size() != 1) begin
      errors++; $display("[TB] FAIL fetch_ce_count: got %0d expected 1", ceLog.size());
    end else if (ceLog[0].cyc != t0 + 1 || ceLog[0].we !== 1'b0 || ceLog[0].sel !== 4'hF ||
                 ceLog[0].addr !== 32'h100 || ceLog[0].wdata !== 32'h0) begin
      errors++; $display("[TB] FAIL fetch_cmd: got cyc %0d we %b sel %h addr %h wd %h expected cyc %0d we 0 sel f addr 100 wd 0",
                         ceLog[0].cyc - t0, ceLog[0].we, ceLog[0].sel, ceLog[0].addr, ceLog[0].wdata, 1);
    end
  endtask

  task automatic test_data_write();
    int t0, at;
    logic isD;
    logic [31:0] rd;
    exp_t e;
    ceLog.delete();
    t0 = cycNum;
    m.d_we = 1'b1; m.d_sel = 4'b0011; m.d_addr = 32'h20; m.d_wdata = 32'hDEADBEEF; m.d_req = 1'b1;
    scoreQ.push_back('{1'b1, 32'h0});
    serveAck(12, isD, rd, at);
    m.d_we = 1'b0;
    checks++;
    if (at != t0 + 4) begin
      errors++; $display("[TB] FAIL write_ack_cycle: got %0d expected %0d", at - t0, 4);
    end
    checks++;
    e = scoreQ.pop_front();
    if (isD !== e.isData || rd !== e.rdata) begin
      errors++; $display("[TB] FAIL write_ack: got data=%b rdata %h expected data=%b rdata %h", isD, rd, e.isData, e.rdata);
    end
    checks++;
    if (ceLog.size() != 1) begin
      errors++; $display("[TB] FAIL write_ce_count: got %0d expected 1", ceLog.size());
    end else if (ceLog[0].cyc != t0 + 1 || ceLog[0].we !== 1'b1 || ceLog[0].sel !== 4'b0011 ||
                 ceLog[0].addr !== 32'h20 || ceLog[0].wdata !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL write_cmd: got cyc %0d we %b sel %h addr %h wd %h expected cyc 1 we 1 sel 3 addr 20 wd deadbeef",
                         ceLog[0].cyc - t0, ceLog[0].we, ceLog[0].sel, ceLog[0].addr, ceLog[0].wdata);
    end
  endtask

  task automatic test_simultaneous();
    int t0, at;
    logic isD;
    logic [31:0] rd;
    exp_t e;
    ceLog.delete();
    t0 = cycNum;
    m.d_we = 1'b0; m.d_addr = 32'h40; m.if_addr = 32'h104;
    m.d_req = 1'b1; m.if_req = 1'b1;
    scoreQ.push_back('{1'b1, memWord(32'h40)});
    scoreQ.push_back('{1'b0, memWord(32'h104)});
    serveAck(12, isD, rd, at);
    e = scoreQ.pop_front();
    checks++;
    if (at != t0 + 4 || isD !== e.isData || rd !== e.rdata) begin
      errors++; $display("[TB] FAIL simul_first: got cyc %0d data=%b rdata %h expected cyc 4 data=%b rdata %h",
                         at - t0, isD, rd, e.isData, e.rdata);
    end
    serveAck(12, isD, rd, at);
    e = scoreQ.pop_front();
    checks++;
    if (at != t0 + 9 || isD !== e.isData || rd !== e.rdata) begin
      errors++; $display("[TB] FAIL simul_second: got cyc %0d data=%b rdata %h expected cyc 9 data=%b rdata %h",
                         at - t0, isD, rd, e.isData, e.rdata);
    end
    checks++;
    if (ceLog.size() != 2) begin
      errors++; $display("[TB] FAIL simul_ce_count: got %0d expected 2", ceLog.size());
    end else if (ceLog[0].addr !== 32'h40 || ceLog[1].addr !== 32'h104 || ceLog[1].cyc != t0 + 6) begin
      errors++; $display("[TB] FAIL simul_cmd: got addr %h/%h fetch ce cyc %0d expected 40/104 cyc 6",
                         ceLog[0].addr, ceLog[1].addr, ceLog[1].cyc - t0);
    end
  endtask

  task automatic test_starvation();
    logic [5:0] order;
    int at, prevAt;
    logic isD, expD;
    logic [31:0] rd;
    exp_t e;
    order = 6'b101111;
    prevAt = -1;
    m.d_we = 1'b0; m.d_addr = 32'h200; m.if_addr = 32'h300;
    m.d_req = 1'b1; m.if_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      expD = order[g];
      scoreQ.push_back('{expD, memWord(expD ? m.d_addr : m.if_addr)});
      serveAck(12, isD, rd, at);
      e = scoreQ.pop_front();
      checks++;
      if (at < 0 || isD !== e.isData || rd !== e.rdata) begin
        errors++; $display("[TB] FAIL starve_grant%0d: got cyc %0d data=%b rdata %h expected data=%b rdata %h",
                           g, at, isD, rd, e.isData, e.rdata);
      end
      if (prevAt >= 0) begin
        checks++;
        if (at - prevAt != 5) begin
          errors++; $display("[TB] FAIL starve_spacing%0d: got %0d expected 5", g, at - prevAt);
        end
      end
      if (g == 3) begin
        checks++;
        if (dut.r_starveCnt !== 4'd4) begin
          errors++; $display("[TB] FAIL starve_cnt_sat: got %0d expected 4", dut.r_starveCnt);
        end
      end
      if (g == 4) begin
        checks++;
        if (dut.r_starveCnt !== 4'd0) begin
          errors++; $display("[TB] FAIL starve_cnt_clear: got %0d expected 0", dut.r_starveCnt);
        end
      end
      prevAt = at;
      if (at < 0) break;
      if (g < 5) begin
        if (isD) begin m.d_addr = m.d_addr + 32'd4; m.d_req = 1'b1; end
        else begin m.if_addr = m.if_addr + 32'd4; m.if_req = 1'b1; end
      end
    end
    m.d_req = 1'b0; m.if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    int t0, tRel, at;
    logic isD;
    logic [31:0] rd;
    exp_t e;
    ceLog.delete(); ackLog.delete();
    t0 = cycNum;
    m.d_we = 1'b0; m.d_addr = 32'h80; m.d_req = 1'b1;
    scoreQ.push_back('{1'b1, memWord(32'h80)});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m.mem_ce, m.mem_we, m.d_ack, m.if_ack, m.stall_req_mem, m.stall_req_if} !== 6'b0 ||
        {m.mem_sel, m.mem_addr, m.mem_wdata, m.d_rdata} !== 100'h0) begin
      errors++; $display("[TB] FAIL midrst_outputs: got ctrl %b addr %h rdata %h expected all 0",
                         {m.mem_ce, m.mem_we, m.d_ack, m.if_ack, m.stall_req_mem, m.stall_req_if}, m.mem_addr, m.d_rdata);
    end
    checks++;
    if (dut.r_state !== 2'd0) begin
      errors++; $display("[TB] FAIL midrst_state: got %0d expected 0", dut.r_state);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    tRel = cycNum;
    serveAck(12, isD, rd, at);
    e = scoreQ.pop_front();
    checks++;
    if (at != tRel + 4 || isD !== e.isData || rd !== e.rdata) begin
      errors++; $display("[TB] FAIL midrst_regrant: got cyc %0d data=%b rdata %h expected cyc 4 data=%b rdata %h",
                         at - tRel, isD, rd, e.isData, e.rdata);
    end
    checks++;
    if (ackLog.size() != 1 || ceLog.size() != 2) begin
      errors++; $display("[TB] FAIL midrst_counts: got acks %0d ces %0d expected 1 2", ackLog.size(), ceLog.size());
    end else if (ceLog[1].cyc != tRel + 1) begin
      errors++; $display("[TB] FAIL midrst_ce_cycle: got %0d expected 1", ceLog[1].cyc - tRel);
    end
  endtask

  task automatic test_latency_sweep();
    int ack1, ack7;
    logic [31:0] rd1, rd7;
    ack1 = -1; ack7 = -1; rd1 = '0; rd7 = '0;
    l1.if_addr = 32'h100; l7.if_addr = 32'h180;
    l1.if_req = 1'b1; l7.if_req = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ack1 < 0 && l1.if_ack === 1'b1) begin ack1 = k; rd1 = l1.if_rdata; end
      if (ack7 < 0 && l7.if_ack === 1'b1) begin ack7 = k; rd7 = l7.if_rdata; end
      @(posedge clk); #1;
      if (ack1 >= 0) l1.if_req = 1'b0;
      if (ack7 >= 0) l7.if_req = 1'b0;
    end
    checks++;
    if (ack1 != 3 || rd1 !== memWord(32'h100)) begin
      errors++; $display("[TB] FAIL lat1_fetch: got cyc %0d rdata %h expected cyc 3 rdata %h", ack1, rd1, memWord(32'h100));
    end
    checks++;
    if (ack7 != 9 || rd7 !== memWord(32'h180)) begin
      errors++; $display("[TB] FAIL lat7_fetch: got cyc %0d rdata %h expected cyc 9 rdata %h", ack7, rd7, memWord(32'h180));
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (dualAck != 0) begin
      errors++; $display("[TB] FAIL dual_ack: got %0d expected 0", dualAck);
    end
    checks++;
    if (scoreQ.size() != 0) begin
      errors++; $display("[TB] FAIL score_leftover: got %0d expected 0", scoreQ.size());
    end
  endtask

  initial begin
    m.if_req = 1'b0; m.if_addr = '0; m.d_req = 1'b0; m.d_we = 1'b0; m.d_sel = 4'hF; m.d_addr = '0; m.d_wdata = '0;
    l1.if_req = 1'b0; l1.if_addr = '0; l1.d_req = 1'b0; l1.d_we = 1'b0; l1.d_sel = '0; l1.d_addr = '0; l1.d_wdata = '0;
    l7.if_req = 1'b0; l7.if_addr = '0; l7.d_req = 1'b0; l7.d_we = 1'b0; l7.d_sel = '0; l7.d_addr = '0; l7.d_wdata = '0;
    test_reset();
    test_fetch_only();
    test_data_write();
    test_simultaneous();
    test_starvation();
    test_reset_midop();
    test_latency_sweep();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/openmips_mem_arbiter.md
# openmips_mem_arbiter

Arbitrates a single synchronous, single-port memory between the OpenMIPS instruction-fetch port and the data-access (MEM stage) port inside `openmips_min_sopc`. Sequences each access through a fixed-latency issue/wait/ack cycle. Returns read data with a one-cycle ack pulse. Raises per-port stall requests toward the pipeline `ctrl` unit while an access is outstanding. Data accesses have priority, and a starvation counter guarantees fetch progress.

## Interface
- `DATA_W`, 32, data and address width
- `MEM_LAT`, 2, cycles from the `mem_ce` cycle to valid `mem_rdata` (1..7)
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits (1..15)

- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  synchronous reset, active-low (sampled on `clk`)
- `if_req`  in  1  fetch request, held until `if_ack`
- `if_addr`  in  DATA_W  fetch address, stable while `if_req`
- `if_rdata`  out  DATA_W  fetched word, valid in `if_ack` cycle
- `if_ack`  out  1  one-cycle completion pulse
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_sel`  in  4  byte enables
- `d_addr`  in  DATA_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_rdata`  out  DATA_W  read data, valid in `d_ack` cycle
- `d_ack`  out  1  one-cycle completion pulse
- `mem_ce`, `mem_we`  out  1  memory chip enable / write enable
- `mem_sel`  out  4  memory byte enables
- `mem_addr`, `mem_wdata`  out  DATA_W  memory command
- `mem_rdata`  in  DATA_W  memory read data
- `stall_req_if`, `stall_req_mem`  out  1  stall requests to `ctrl`

## Operation
- FSM states: IDLE → ISSUE → WAIT → ACK → IDLE.
- IDLE: sample requests.
  - Neither request: stay in IDLE.
  - Otherwise pick the owner: data if `d_req`, unless `if_req` and `starve_cnt == STARVE_MAX`, in which case fetch. Fetch if only `if_req`.
  - Register the owner's command into the `mem_*` registers. Go to ISSUE.
- Fetch commands use `mem_we=0`, `mem_sel=4'b1111`, `mem_wdata=0`.
- ISSUE: `mem_ce=1`, `mem_we` per command, for exactly this cycle. Load `lat_cnt = MEM_LAT-1`. Go to WAIT.
- WAIT: decrement `lat_cnt`. At zero, capture `mem_rdata` into the owner's `*_rdata` register. Go to ACK.
  - Writes capture 0.
- ACK: the owner's `*_ack=1` for one cycle. Go to IDLE.
- The non-owner's `*_rdata` holds its previous value.
- Outside ISSUE: `mem_ce=mem_we=0`; `mem_addr`, `mem_sel`, `mem_wdata` hold their last values.
- Starvation counter (`starve_cnt`, saturating at STARVE_MAX):
  - +1 on each data grant while `if_req=1`.
  - Cleared on a fetch grant.
  - Cleared at any IDLE arbitration where `if_req=0`.
- Stall requests:
  - `stall_req_if = if_req & ~if_ack`.
  - `stall_req_mem = d_req & ~d_ack`.
  - Both forced to 0 while `rst=0`.
- A requester drops `req` or presents a new command in the cycle after ack. IDLE samples the new state then; stale requests are never re-granted inside ACK.
- Inputs of the non-owner may change freely during a transaction.

## Timing
- Reset (`rst=0` at an edge): FSM=IDLE, `starve_cnt=0`, `lat_cnt=0`.
  - All outputs become 0: `mem_*`, `*_ack`, `*_rdata`, stalls.
- Reset mid-transaction aborts the access; no ack is issued, and `mem_rdata` of the aborted read is ignored.
- Request sampled in IDLE at cycle 0:
  - `mem_ce` in cycle 1.
  - `mem_rdata` sampled in cycle 1+MEM_LAT.
  - Ack in cycle 2+MEM_LAT.
- Minimum request-to-ack latency is MEM_LAT+2. Back-to-back grant spacing is MEM_LAT+3 cycles.
- When both ports request in the same IDLE cycle and the counter has not saturated, data wins; fetch is served in the next IDLE cycle.
- Exactly one `mem_ce` pulse and one ack pulse per granted request; `if_ack` and `d_ack` are never high together.

## Test plan
- Fetch only, MEM_LAT=2: `if_req`, `if_addr=0x100` at cycle 0 → `mem_ce=1`, `mem_addr=0x100`, `mem_we=0`, `mem_sel=4'hF` at cycle 1; memory returns `0x3C010101` at cycle 3 → `if_ack=1`, `if_rdata=0x3C010101` at cycle 4; `stall_req_if` high in cycles 0–3.
- Data write: `d_we=1`, `d_sel=4'b0011`, `d_addr=0x20`, `d_wdata=0xDEADBEEF` → one `mem_ce` cycle with `mem_we=1` and those values; `d_ack` 3 cycles later; `d_rdata=0`.
- Simultaneous `if_req` and `d_req` in IDLE → data granted first (`d_ack` at cycle 4). Fetch `mem_ce` follows at cycle 6, `if_ack` at cycle 9.
- Starvation: `d_req` and `if_req` held continuously, STARVE_MAX=4 → grant order D,D,D,D,IF,D…; `starve_cnt` returns to 0 after the fetch grant.
- Reset mid-op: `rst=0` during WAIT of a data read → next cycle all outputs 0, FSM in IDLE, no `d_ack`. After release, the held `d_req` is re-granted with full MEM_LAT+2 latency.
- MEM_LAT=1 and MEM_LAT=7 sweeps of the single-fetch case → ack at cycles 3 and 9 respectively.
